// File: rtl/pd_tx_arb.sv
// Three-requester arbiter in front of the PRL transmit request interface.
// Build with PD_TX_ARB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2 instead of round-robin.
`timescale 1ns/1ps
module pd_tx_arb #(
  parameter int TIMEOUT_CYCLES = 2400,
  parameter int TMR_W          = 12    // 2**TMR_W must exceed TIMEOUT_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req,
  input  logic [20:0]   req_type,
  input  logic [8:0]    req_sop_type,
  input  logic [14:0]   req_info,
  input  logic [107:0]  req_ex_info,
  output logic [2:0]    done,
  output logic [1:0]    done_result,
  output logic          busy,
  output logic          pe2pl_tx_en,
  output logic [6:0]    pe2pl_tx_type,
  output logic [2:0]    pe2pl_tx_sop_type,
  output logic [4:0]    pe2pl_tx_info,
  output logic [35:0]   pe2pl_tx_ex_info,
  input  logic          pl2pe_tx_ack,
  input  logic [1:0]    pl2pe_tx_result,
  input  logic          pl2pe_hard_reset_req
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic [1:0]       grant, win;
  logic             start, finish, timeout;
  logic [1:0]       fin_result;
  logic [6:0]       sel_type;
  logic [2:0]       sel_sop;
  logic [4:0]       sel_info;
  logic [35:0]      sel_ex;

  assign timeout = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

`ifdef PD_TX_ARB_FIXED_PRIO_EN
  always_comb begin
    if (req[0])      win = 2'd0;
    else if (req[1]) win = 2'd1;
    else             win = 2'd2;
  end
`else
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  logic [1:0] ptr, cand1, cand2;
  logic       adv_ptr;

  assign cand1 = inc3(ptr);
  assign cand2 = inc3(cand1);

  always_comb begin
    if (req[ptr])        win = ptr;
    else if (req[cand1]) win = cand1;
    else                 win = cand2;
  end

  // A hard-reset abort leaves the pointer alone so the aborted requester keeps its turn.
  assign adv_ptr = (state == SEND) && !pl2pe_hard_reset_req && (pl2pe_tx_ack || timeout);

  always_ff @(posedge clk) begin
    if (rst)          ptr <= 2'd0;
    else if (adv_ptr) ptr <= inc3(grant);
  end
`endif

  always_comb begin
    case (win)
      2'd1: begin
        sel_type = req_type[13:7];     sel_sop = req_sop_type[5:3];
        sel_info = req_info[9:5];      sel_ex  = req_ex_info[71:36];
      end
      2'd2: begin
        sel_type = req_type[20:14];    sel_sop = req_sop_type[8:6];
        sel_info = req_info[14:10];    sel_ex  = req_ex_info[107:72];
      end
      default: begin
        sel_type = req_type[6:0];      sel_sop = req_sop_type[2:0];
        sel_info = req_info[4:0];      sel_ex  = req_ex_info[35:0];
      end
    endcase
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    finish     = 1'b0;
    fin_result = 2'b11;
    case (state)
      IDLE: begin
        if (!pl2pe_hard_reset_req && |req) begin
          start     = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (pl2pe_hard_reset_req || pl2pe_tx_ack || timeout) begin
          finish     = 1'b1;
          state_nxt  = GAP;
          // Hard reset wins; an ack beats a simultaneous timeout.
          fin_result = (!pl2pe_hard_reset_req && pl2pe_tx_ack) ? pl2pe_tx_result : 2'b11;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant             <= 2'd0;
      timer             <= '0;
      done              <= 3'b000;
      done_result       <= 2'b00;
      busy              <= 1'b0;
      pe2pl_tx_en       <= 1'b0;
      pe2pl_tx_type     <= '0;
      pe2pl_tx_sop_type <= '0;
      pe2pl_tx_info     <= '0;
      pe2pl_tx_ex_info  <= '0;
    end else begin
      done <= 3'b000;
      if (start) begin
        grant             <= win;
        timer             <= '0;
        busy              <= 1'b1;
        pe2pl_tx_en       <= 1'b1;
        pe2pl_tx_type     <= sel_type;
        pe2pl_tx_sop_type <= sel_sop;
        pe2pl_tx_info     <= sel_info;
        pe2pl_tx_ex_info  <= sel_ex;
      end else if (finish) begin
        busy        <= 1'b0;
        pe2pl_tx_en <= 1'b0;
        done        <= 3'b001 << grant;
        done_result <= fin_result;
      end else if (state == SEND && timer != '1) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pd_tx_arb.sv
// Scoreboard bench for pd_tx_arb: expected grants/completions are queued as
// stimulus is applied and matched when the DUT raises tx_en or pulses done.
`timescale 1ns/1ps
module tb_pd_tx_arb;

  localparam int TO = 2400;
`ifdef PD_TX_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] mask;
    logic [1:0] res;
  } done_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req;
  logic [20:0]  req_type;
  logic [8:0]   req_sop_type;
  logic [14:0]  req_info;
  logic [107:0] req_ex_info;
  logic [2:0]   done;
  logic [1:0]   done_result;
  logic         busy;
  logic         pe2pl_tx_en;
  logic [6:0]   pe2pl_tx_type;
  logic [2:0]   pe2pl_tx_sop_type;
  logic [4:0]   pe2pl_tx_info;
  logic [35:0]  pe2pl_tx_ex_info;
  logic         pl2pe_tx_ack;
  logic [1:0]   pl2pe_tx_result;
  logic         pl2pe_hard_reset_req;

  int unsigned grant_q[$];
  done_t       done_q[$];
  int          n_checks = 0;
  int          n_err    = 0;

  always #5 clk = ~clk;

  pd_tx_arb #(.TIMEOUT_CYCLES(TO), .TMR_W(12)) dut (
    .clk(clk), .rst(rst), .req(req), .req_type(req_type),
    .req_sop_type(req_sop_type), .req_info(req_info), .req_ex_info(req_ex_info),
    .done(done), .done_result(done_result), .busy(busy),
    .pe2pl_tx_en(pe2pl_tx_en), .pe2pl_tx_type(pe2pl_tx_type),
    .pe2pl_tx_sop_type(pe2pl_tx_sop_type), .pe2pl_tx_info(pe2pl_tx_info),
    .pe2pl_tx_ex_info(pe2pl_tx_ex_info), .pl2pe_tx_ack(pl2pe_tx_ack),
    .pl2pe_tx_result(pl2pe_tx_result), .pl2pe_hard_reset_req(pl2pe_hard_reset_req)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [50:0] fields_of(input int unsigned idx);
    case (idx)
      0:       return {7'h03, 3'd0, 5'h01, 36'h0_0000_00A0};
      1:       return {7'h15, 3'd1, 5'h0A, 36'h1_2345_6789};
      default: return {7'h6E, 3'd2, 5'h1F, 36'hF_EDCB_A987};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_grant(input int unsigned idx);
    grant_q.push_back(idx);
  endtask

  task automatic exp_done(input int unsigned idx, input logic [1:0] res);
    done_t d;
    d.mask = 3'b001 << idx;
    d.res  = res;
    done_q.push_back(d);
  endtask

  task automatic wait_tx();
    int n = 0;
    while (!pe2pl_tx_en && n < 20) begin
      tick();
      n++;
    end
    check("wait_tx", pe2pl_tx_en, 1);
  endtask

  // Ack on the cyc-th cycle of tx_en high; returns in the GAP cycle.
  task automatic serve(input int cyc, input logic [1:0] res);
    wait_tx();
    repeat (cyc - 1) tick();
    pl2pe_tx_result = res;
    pl2pe_tx_ack    = 1'b1;
    tick();
    pl2pe_tx_ack    = 1'b0;
    pl2pe_tx_result = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: grant fields on each tx_en rise, completions on each done pulse.
  logic        prev_tx = 1'b0;
  int unsigned mon_idx;
  done_t       mon_d;
  always @(negedge clk) begin
    if (pe2pl_tx_en && !prev_tx) begin
      if (grant_q.size() == 0) check("unexp_grant", 1, 0);
      else begin
        mon_idx = grant_q.pop_front();
        check("grant_fields", {pe2pl_tx_type, pe2pl_tx_sop_type, pe2pl_tx_info, pe2pl_tx_ex_info},
              fields_of(mon_idx));
        check("grant_busy", busy, 1);
      end
    end
    prev_tx = pe2pl_tx_en;
    if (done != 3'b000) begin
      if (done_q.size() == 0) check("unexp_done", done, 0);
      else begin
        mon_d = done_q.pop_front();
        check("done_mask", done, mon_d.mask);
        check("done_res", done_result, mon_d.res);
      end
    end
  end

  initial begin
    int hi;
    int cnt;
    rst                  = 1'b1;
    req                  = 3'b000;
    req_type             = {7'h6E, 7'h15, 7'h03};
    req_sop_type         = {3'd2, 3'd1, 3'd0};
    req_info             = {5'h1F, 5'h0A, 5'h01};
    req_ex_info          = {36'hF_EDCB_A987, 36'h1_2345_6789, 36'h0_0000_00A0};
    pl2pe_tx_ack         = 1'b0;
    pl2pe_tx_result      = 2'b00;
    pl2pe_hard_reset_req = 1'b0;
    repeat (2) tick();
    check("rst_ctrl", {pe2pl_tx_en, busy, done, done_result}, 0);
    check("rst_fields", {pe2pl_tx_type, pe2pl_tx_sop_type, pe2pl_tx_info, pe2pl_tx_ex_info}, 0);
    rst = 1'b0;
    tick();

    // Single request, ack on the 10th cycle of tx_en.
    req = 3'b001;
    exp_grant(0);
    exp_done(0, 2'b00);
    tick();
    check("t1_latency", pe2pl_tx_en, 1);
    hi = 1;
    for (int k = 1; k < 10; k++) begin
      tick();
      if (pe2pl_tx_en) hi++;
    end
    check("t1_hold", hi, 10);
    pl2pe_tx_ack = 1'b1;
    tick();
    pl2pe_tx_ack = 1'b0;
    req = 3'b000;
    check("t1_drop", {pe2pl_tx_en, busy}, 0);
    tick();
    check("t1_gap", {pe2pl_tx_en, done}, 0);

    // Contention from pointer 0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_grant(FIXED ? 0 : i % 3);
      exp_done(FIXED ? 0 : i % 3, 2'b00);
    end
    req = 3'b111;
    for (int i = 0; i < 6; i++) serve(3, 2'b00);
    req = 3'b000;
    repeat (2) tick();

    // Timeout on requester 1; pointer then starts at requester 2.
    req = 3'b010;
    exp_grant(1);
    exp_done(1, 2'b11);
    wait_tx();
    cnt = 0;
    while (pe2pl_tx_en && cnt < 3000) begin
      cnt++;
      tick();
    end
    check("to_len", cnt, TO);
    check("to_busy", busy, 0);
    req = 3'b111;
    exp_grant(FIXED ? 0 : 2);
    exp_done(FIXED ? 0 : 2, 2'b00);
    serve(3, 2'b00);
    req = 3'b000;
    repeat (2) tick();

    // Move pointer to 1, then abort a grant of requester 2 with hard reset.
    req = 3'b001;
    exp_grant(0);
    exp_done(0, 2'b00);
    serve(2, 2'b00);
    req = 3'b000;
    repeat (2) tick();
    req = 3'b100;
    exp_grant(2);
    exp_done(2, 2'b11);
    wait_tx();
    repeat (4) tick();
    pl2pe_hard_reset_req = 1'b1;
    tick();
    check("hr_txen", pe2pl_tx_en, 0);
    req = 3'b111;
    repeat (5) tick();
    check("hr_nogrant", {pe2pl_tx_en, busy}, 0);
    exp_grant(FIXED ? 0 : 1);
    exp_done(FIXED ? 0 : 1, 2'b00);
    pl2pe_hard_reset_req = 1'b0;
    serve(3, 2'b00);
    req = 3'b000;
    repeat (2) tick();

    // Ack lands on the timeout cycle: ack result wins.
    req = 3'b001;
    exp_grant(0);
    exp_done(0, 2'b10);
    wait_tx();
    repeat (TO - 1) tick();
    check("co_pre", pe2pl_tx_en, 1);
    pl2pe_tx_result = 2'b10;
    pl2pe_tx_ack    = 1'b1;
    tick();
    pl2pe_tx_ack    = 1'b0;
    pl2pe_tx_result = 2'b00;
    req = 3'b000;
    check("co_drop", pe2pl_tx_en, 0);

    // Spurious ack in IDLE.
    tick();
    pl2pe_tx_result = 2'b01;
    pl2pe_tx_ack    = 1'b1;
    tick();
    pl2pe_tx_ack    = 1'b0;
    pl2pe_tx_result = 2'b00;
    check("sp_idle", {pe2pl_tx_en, busy, done}, 0);
    tick();
    check("sp_after", {pe2pl_tx_en, done}, 0);

    // Reset mid-SEND, then the still-pending request is serviced.
    req = 3'b001;
    exp_grant(0);
    wait_tx();
    repeat (3) tick();
    rst = 1'b1;
    exp_grant(0);
    exp_done(0, 2'b00);
    tick();
    check("mr_state", {pe2pl_tx_en, busy, done}, 0);
    rst = 1'b0;
    serve(4, 2'b00);
    req = 3'b000;
    repeat (3) tick();

    check("sb_grant_left", grant_q.size(), 0);
    check("sb_done_left", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
